// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, widths and FSM state encoding.
package des_pkg;
  localparam int KEY_W = 64;
  localparam int CD_W = 56;
  localparam int SK_W = 48;
  localparam int HALF_W = 28;
  typedef enum logic {IDLE, GEN} state_t;
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Bit n in DES numbering (1 = MSB) lives at index [W+1-n].
  function automatic logic [CD_W:1] perm_pc1(input logic [KEY_W:1] k);
    perm_pc1 = '0;
    for (int i = 0; i < CD_W; i++) perm_pc1[CD_W - i] = k[KEY_W + 1 - PC1[i]];
  endfunction
  function automatic logic [HALF_W:1] rol(input logic [HALF_W:1] x, input logic two);
    return two ? {x[HALF_W-2:1], x[HALF_W:HALF_W-1]} : {x[HALF_W-1:1], x[HALF_W]};
  endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: load request and subkey valid/ready stream of the key schedule.
interface des_key_schedule_if;
  import des_pkg::*;
  logic [KEY_W:1] key_in;
  logic load;
  logic decrypt;
  logic busy;
  logic [SK_W:1] subkey;
  logic subkey_valid;
  logic subkey_ready;
  logic [3:0] round;
  logic done;
  modport master (
    input key_in, load, decrypt, subkey_ready,
    output busy, subkey, subkey_valid, round, done
  );
  modport slave (
    output key_in, load, decrypt, subkey_ready,
    input busy, subkey, subkey_valid, round, done
  );
endinterface

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1] cd_i,
  output logic [SK_W:1] k_o
);
  always_comb begin
    k_o = '0;
    for (int i = 0; i < SK_W; i++) k_o[SK_W - i] = cd_i[CD_W + 1 - PC2[i]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: streams the 16 DES round subkeys over a valid/ready handshake.
// Define DES_KS_DECRYPT_EN to honour decrypt (K16..K1 order); otherwise encrypt order only.
module des_key_schedule
  import des_pkg::*;
(
  input logic clk,
  input logic rst,
  des_key_schedule_if.master bus
);
  state_t state_q, state_d;
  logic [HALF_W:1] c_q, c_d, d_q, d_d, ld_c, ld_d, nx_c, nx_d;
  logic [3:0] round_q, round_d;
  logic done_q, done_d;
  logic [CD_W:1] cd0;
  logic xfer, accept, last;
  assign cd0 = perm_pc1(bus.key_in);
  assign accept = state_q == IDLE && bus.load;
  assign xfer = state_q == GEN && bus.subkey_ready;
  assign last = round_q == 4'd15;
`ifdef DES_KS_DECRYPT_EN
  logic dec_q;
  function automatic logic [HALF_W:1] ror(input logic [HALF_W:1] x, input logic two);
    return two ? {x[2:1], x[HALF_W:3]} : {x[1], x[HALF_W:2]};
  endfunction
  // Decrypt starts from the unrotated halves: 28 total left shifts is the identity.
  assign ld_c = bus.decrypt ? cd0[CD_W:HALF_W+1] : rol(cd0[CD_W:HALF_W+1], SHIFTS[0] == 2);
  assign ld_d = bus.decrypt ? cd0[HALF_W:1] : rol(cd0[HALF_W:1], SHIFTS[0] == 2);
  assign nx_c = dec_q ? ror(c_q, SHIFTS[4'd15 - round_q] == 2) : rol(c_q, SHIFTS[round_q + 4'd1] == 2);
  assign nx_d = dec_q ? ror(d_q, SHIFTS[4'd15 - round_q] == 2) : rol(d_q, SHIFTS[round_q + 4'd1] == 2);
  always_ff @(posedge clk or posedge rst)
    if (rst) dec_q <= 1'b0;
    else if (accept) dec_q <= bus.decrypt;
`else
  assign ld_c = rol(cd0[CD_W:HALF_W+1], SHIFTS[0] == 2);
  assign ld_d = rol(cd0[HALF_W:1], SHIFTS[0] == 2);
  assign nx_c = rol(c_q, SHIFTS[round_q + 4'd1] == 2);
  assign nx_d = rol(d_q, SHIFTS[round_q + 4'd1] == 2);
`endif
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    d_d = d_q;
    round_d = round_q;
    done_d = xfer && last;
    if (accept) begin
      state_d = GEN;
      c_d = ld_c;
      d_d = ld_d;
      round_d = '0;
    end else if (xfer) begin
      state_d = last ? IDLE : GEN;
      c_d = last ? c_q : nx_c;
      d_d = last ? d_q : nx_d;
      round_d = last ? round_q : round_q + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      d_q <= '0;
      round_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      d_q <= d_d;
      round_q <= round_d;
      done_q <= done_d;
    end
  assign bus.busy = state_q == GEN;
  assign bus.subkey_valid = state_q == GEN;
  assign bus.round = round_q;
  assign bus.done = done_q;
  des_pc2 u_pc2 (.cd_i({c_q, d_q}), .k_o(bus.subkey));
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed vectors against a cumulative-rotation DES key schedule model.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  des_key_schedule_if bus();
  des_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
`ifdef DES_KS_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] K2 = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
  localparam int TPC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29,
    21,13,5,28,20,12,4};
  localparam int TPC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int TSH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  typedef logic [15:0][47:0] ks_t;
  // Each subkey from the total left rotation of C0/D0; decrypt is the reversed list.
  function automatic ks_t sched(input logic [63:0] k, input logic dec);
    ks_t ks;
    logic [27:0] c0, d0;
    logic [55:0] tc, td, cd;
    int cum = 0;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = k[64-TPC1[i]];
      d0[27-i] = k[64-TPC1[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      cum += TSH[r];
      tc = {c0, c0} << cum;
      td = {d0, d0} << cum;
      cd = {tc[55:28], td[55:28]};
      for (int j = 0; j < 48; j++) ks[dec ? 15-r : r][47-j] = cd[56-TPC2[j]];
    end
    return ks;
  endfunction
  ks_t m_keys;
  logic m_busy, m_done;
  logic [3:0] m_round;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_keys <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_round <= '0;
    end else begin
      m_done <= m_busy && bus.subkey_ready && m_round == 4'd15;
      if (!m_busy && bus.load) begin
        m_busy <= 1'b1;
        m_round <= '0;
        m_keys <= sched(bus.key_in, bus.decrypt & DEC_EN);
      end else if (m_busy && bus.subkey_ready) begin
        if (m_round == 4'd15) m_busy <= 1'b0;
        else m_round <= m_round + 4'd1;
      end
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("busy", bus.busy, m_busy);
      chk("valid", bus.subkey_valid, m_busy);
      chk("done", bus.done, m_done);
      if (m_busy) begin
        chk("round", bus.round, m_round);
        chk("subkey", bus.subkey, m_keys[m_round]);
      end
    end
  task automatic start(input logic [63:0] k, input logic dec);
    bus.key_in = k;
    bus.decrypt = dec;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (m_round != r && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1'b1);
  endtask
  ks_t ref_ks;
  logic [47:0] last_key;
  int n;
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.key_in = '0;
    bus.load = 1'b0;
    bus.decrypt = 1'b0;
    bus.subkey_ready = 1'b1;
    ref_ks = sched(KEY, 1'b0);
    chk("model_k1", ref_ks[0], K1);
    chk("model_k2", ref_ks[1], K2);
    chk("model_k16", ref_ks[15], K16);
    repeat (2) @(negedge clk);
    chk("rst_subkey", bus.subkey, 48'h0);
    chk("rst_valid", bus.subkey_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // Encrypt order, full speed, done latency from the load cycle.
    start(KEY, 1'b0);
    chk("enc_first", bus.subkey, K1);
    chk("enc_round0", bus.round, 4'd0);
    n = 1;
    last_key = '0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.subkey_valid && bus.round == 4'd15) last_key = bus.subkey;
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 17);
    chk("enc_last", last_key, K16);
    repeat (2) @(negedge clk);
    // Stall at round 3.
    start(KEY, 1'b0);
    wait_round(4'd3);
    bus.subkey_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_round", bus.round, 4'd3);
      chk("stall_key", bus.subkey, ref_ks[3]);
      chk("stall_valid", bus.subkey_valid, 1'b1);
    end
    bus.subkey_ready = 1'b1;
    wait_done();
    // Load while busy is ignored.
    start(KEY, 1'b0);
    wait_round(4'd7);
    bus.key_in = 64'h0123456789ABCDEF;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("ign_key", bus.subkey, ref_ks[8]);
    wait_done();
    // Reset mid-run then reload.
    start(KEY, 1'b0);
    wait_round(4'd9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.subkey_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_subkey", bus.subkey, 48'h0);
    @(negedge clk);
    rst = 1'b0;
    start(KEY, 1'b0);
    chk("restart_k1", bus.subkey, K1);
    chk("restart_round", bus.round, 4'd0);
    // Back-to-back: load in the done cycle.
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done", bus.done, 1'b1);
    start(64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("b2b_valid", bus.subkey_valid, 1'b1);
    chk("b2b_ones", bus.subkey, 48'hFFFFFFFFFFFF);
    wait_done();
    // Parity bits alone must give all-zero subkeys.
    start(64'h0101010101010101, 1'b0);
    chk("parity_zero", bus.subkey, 48'h0);
    wait_done();
    // Decrypt request.
    start(KEY, 1'b1);
    chk("dec_first", bus.subkey, DEC_EN ? K16 : K1);
    n = 1;
    last_key = '0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.subkey_valid && bus.round == 4'd15) last_key = bus.subkey;
      @(negedge clk);
      n++;
    end
    chk("dec_last", last_key, DEC_EN ? K1 : K16);
    // Irregular ready pattern on another key.
    start(64'h0123456789ABCDEF, 1'b0);
    n = 0;
    while (bus.done !== 1'b1 && n < 80) begin
      bus.subkey_ready = n[0] | n[1];
      @(negedge clk);
      n++;
    end
    chk("irregular_done", bus.done, 1'b1);
    bus.subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
